imem_controller: RTL and testbench
==================================

// Module: imem_controller
// PURPOSE
//  Owns the single-port synchronous instruction memory. It loads a program word-by-word
//  from a loader stream (BOOT), then serves the core's fetch requests (RUN). It stops
//  fetching when the unimp halt word is returned (HALT).
//  Sits between loader/fetch stage and the imem array; replaces $readmemh boot in synthesis.
// PARAMETERS
//  DEPTH      1024           imem depth in 32-bit words (power of two)
//  HALT_INSN  32'hc0001073   instruction word that signals end of test (unimp)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   asynchronous, active-high reset
//  ld_valid     in   1   loader word available
//  ld_data      in   32  loader instruction word
//  ld_last      in   1   qualifies ld_data as final program word
//  ld_ready     out  1   controller accepts loader word this cycle
//  fetch_req    in   1   core requests instruction at fetch_addr
//  fetch_addr   in   32  byte address
//  fetch_valid  out  1   fetch_insn valid (1 cycle after accepted req)
//  fetch_insn   out  32  returned instruction
//  fetch_fault  out  1   accepted req was misaligned or out of range
//  core_run     out  1   high in RUN; core may issue fetches
//  halted       out  1   HALT_INSN was fetched; sticky until rst
//  load_count   out  $clog2(DEPTH)+1  words written during BOOT
//  mem_en       out  1   memory port enable
//  mem_we       out  1   memory write enable
//  mem_addr     out  $clog2(DEPTH)  word address
//  mem_wdata    out  32  write data
//  mem_rdata    in   32  read data, valid the cycle after mem_en & !mem_we
// BEHAVIOUR
//  Reset: state=BOOT; ld_ready=1, all other outputs 0, load_count=0, fetch_insn=0.
//  FSM BOOT -> RUN -> HALT. HALT is left only through rst.
//  BOOT: ld_ready=1 while load_count<DEPTH. Handshake occurs on ld_valid&ld_ready.
//   mem_en=mem_we=1, mem_addr=load_count[AW-1:0], mem_wdata=ld_data, combinational same cycle;
//   load_count+1 on the next edge. Transition to RUN after a handshake with ld_last=1, or
//   after the handshake that writes word DEPTH-1 (load_count becomes DEPTH).
//   fetch_req is ignored in BOOT: no valid, no fault.
//  RUN: core_run=1, ld_ready=0. A fetch_req is accepted every cycle (1-deep pipeline, 1-cycle latency).
//   Legal when fetch_addr[1:0]==0 and fetch_addr[31:2]<DEPTH. Then mem_en=1, mem_we=0,
//   mem_addr=fetch_addr[AW+1:2]. Next cycle: fetch_valid=1, fetch_insn=mem_rdata.
//   Illegal: no memory access. Next cycle: fetch_valid=1, fetch_fault=1, fetch_insn=0.
//   No fetch_req: fetch_valid=0 next cycle.
//  Halt: when a returned (non-fault) fetch_insn==HALT_INSN, fetch_valid=1 that cycle,
//   halted=1 and state=HALT from the next edge. A fetch_req in that same cycle is dropped.
//  HALT: core_run=0, ld_ready=0, fetch_valid=0, no memory access, halted=1.
//  rst mid-BOOT or mid-RUN: discard the in-flight fetch, restart BOOT at address 0.
//   Memory contents are not cleared.
//  fetch_valid, fetch_insn and fetch_fault are registered; ld_ready and mem_* are combinational from state.
// STRUCTURE
//  Shared package imem_pkg: IMEM_DEPTH (replaces `imemsize), HALT_INSN, state enum {BOOT,RUN,HALT}.
//  Single module. The memory array stays external (imem_ram) so that it can map to BRAM.
//  The sim-only $display banner and PASSED message move to the testbench, keyed on halted.
// TESTING
//  1. Load 4 words (0x00000013 x3, 0xc0001073 with ld_last) -> mem writes at addr 0..3;
//     load_count=4; core_run rises the next cycle.
//  2. Back-to-back fetch 0x0,0x4,0x8 -> fetch_valid on 3 consecutive cycles, insn=0x00000013 each.
//  3. Fetch 0xC -> fetch_insn=0xc0001073, halted=1 next cycle; a later fetch_req gives no fetch_valid.
//  4. Fetch 0x6 (misaligned) and 0x1000 with DEPTH=1024 -> fetch_fault=1, fetch_insn=0, mem_en=0.
//  5. Stream DEPTH words without ld_last -> RUN entered after word 1023; ld_ready=0 afterwards.
//  6. Assert rst during RUN with a fetch in flight -> fetch_valid=0; state BOOT; ld_ready=1; load_count=0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and state type for the instruction-memory controller.
package imem_pkg;

  localparam int unsigned IMEM_DEPTH = 1024;
  localparam logic [31:0] HALT_INSN  = 32'hc0001073;

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

endpackage

// File: rtl/imem_controller.sv
// Boots the external instruction RAM from a loader stream, then serves core fetches until the
// halt word is returned.
module imem_controller #(
  parameter int unsigned DEPTH     = imem_pkg::IMEM_DEPTH,
  parameter logic [31:0] HALT_INSN = imem_pkg::HALT_INSN,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ld_valid_i,
  input  logic [31:0]   ld_data_i,
  input  logic          ld_last_i,
  output logic          ld_ready_o,
  input  logic          fetch_req_i,
  input  logic [31:0]   fetch_addr_i,
  output logic          fetch_valid_o,
  output logic [31:0]   fetch_insn_o,
  output logic          fetch_fault_o,
  output logic          core_run_o,
  output logic          halted_o,
  output logic [AW:0]   load_count_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i
);

  import imem_pkg::*;

  localparam logic [AW:0] DepthCnt = DEPTH[AW:0];

  state_e      state_q;
  logic [AW:0] load_count_q;
  logic        fetch_valid_q;
  logic        fetch_fault_q;
  logic        rd_pend_q;
  logic        halted_q;

  logic ld_hs;
  logic last_word;
  logic fetch_legal;
  logic fetch_go;
  logic halt_now;

  always_comb begin
    ld_ready_o  = (state_q == StBoot) && (load_count_q < DepthCnt);
    ld_hs       = ld_valid_i && ld_ready_o;
    last_word   = ld_last_i || (load_count_q == DepthCnt - 1'b1);
    // The RAM's output register holds the fetched word; gate it so idle cycles return zero.
    fetch_insn_o = rd_pend_q ? mem_rdata_i : '0;
    halt_now    = fetch_valid_q && !fetch_fault_q && (fetch_insn_o == HALT_INSN);
    fetch_legal = (fetch_addr_i[1:0] == 2'b00) && (fetch_addr_i[31:AW+2] == '0);
    fetch_go    = (state_q == StRun) && fetch_req_i && !halt_now;

    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (ld_hs) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = load_count_q[AW-1:0];
      mem_wdata_o = ld_data_i;
    end else if (fetch_go && fetch_legal) begin
      mem_en_o   = 1'b1;
      mem_addr_o = fetch_addr_i[AW+1:2];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StBoot;
      load_count_q  <= '0;
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      rd_pend_q     <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      rd_pend_q     <= 1'b0;
      unique case (state_q)
        StBoot: begin
          if (ld_hs) begin
            load_count_q <= load_count_q + 1'b1;
            if (last_word) state_q <= StRun;
          end
        end
        StRun: begin
          // A request arriving alongside the halt word is dropped.
          if (halt_now) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else if (fetch_req_i) begin
            fetch_valid_q <= 1'b1;
            fetch_fault_q <= !fetch_legal;
            rd_pend_q     <= fetch_legal;
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  assign fetch_valid_o = fetch_valid_q;
  assign fetch_fault_o = fetch_fault_q;
  assign core_run_o    = (state_q == StRun);
  assign halted_o      = halted_q;
  assign load_count_o  = load_count_q;

endmodule

// File: tb/tb_imem_controller.sv
// Randomised bench for imem_controller with an external RAM model and a fetch scoreboard.
module tb_imem_controller;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam logic [31:0] HALT  = 32'hc0001073;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = '0;
  logic          fetch_valid;
  logic [31:0]   fetch_insn;
  logic          fetch_fault;
  logic          core_run;
  logic          halted;
  logic [AW:0]   load_count;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  imem_controller #(.DEPTH(DEPTH), .HALT_INSN(HALT)) dut (
    .clk_i(clk), .rst_i(rst),
    .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_last_i(ld_last), .ld_ready_o(ld_ready),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_valid_o(fetch_valid),
    .fetch_insn_o(fetch_insn), .fetch_fault_o(fetch_fault), .core_run_o(core_run),
    .halted_o(halted), .load_count_o(load_count),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // External single-port synchronous RAM.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model: program image as written by the loader, plus the controller phase.
  typedef enum {MBoot, MRun, MHalt} mstate_e;
  typedef struct {int due; bit fault; logic [31:0] insn;} exp_t;

  logic [31:0] ref_mem [DEPTH];
  mstate_e     mstate = MBoot;
  int          cnt = 0;
  bit          halt_pend = 1'b0;
  exp_t        sb [$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every returned fetch must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (fetch_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_fetch_valid: got insn %h fault %b want none", fetch_insn,
                   fetch_fault);
        end else begin
          e = sb.pop_front();
          chk("fetch_latency", cyc, e.due);
          chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
          chk("fetch_insn", fetch_insn, e.insn);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        total++; bad++;
        $display("FAIL missing_fetch_valid: got none want insn %h at cycle %0d", e.insn, e.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ld_valid = 1'b0;
    ld_last = 1'b0;
    fetch_req = 1'b0;
    sb.delete();
    mstate = MBoot;
    cnt = 0;
    halt_pend = 1'b0;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("rst_load_count", {21'b0, load_count}, 32'd0);
    chk("rst_core_run", {31'b0, core_run}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_fetch_insn", fetch_insn, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    step();
  endtask

  task automatic load_word(input logic [31:0] d, input bit last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    @(negedge clk);
    chk("ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("ld_mem_en", {31'b0, mem_en}, 32'd1);
    chk("ld_mem_we", {31'b0, mem_we}, 32'd1);
    chk("ld_mem_addr", {22'b0, mem_addr}, cnt);
    chk("ld_mem_wdata", mem_wdata, d);
    step();
    ref_mem[cnt] = d;
    cnt++;
    if (last || cnt == DEPTH) mstate = MRun;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic check_after_load();
    @(negedge clk);
    chk("load_count", {21'b0, load_count}, cnt);
    chk("core_run", {31'b0, core_run}, {31'b0, mstate == MRun});
    chk("ld_ready_after", {31'b0, ld_ready}, {31'b0, mstate == MBoot});
    step();
  endtask

  task automatic drive(input bit req, input logic [31:0] addr);
    bit   legal;
    bit   en;
    exp_t e;
    fetch_req  = req;
    fetch_addr = addr;
    legal = (addr[1:0] == 2'b00) && (addr[31:2] < DEPTH);
    en = 1'b0;
    if (mstate == MRun) begin
      if (halt_pend) begin
        halt_pend = 1'b0;
        mstate = MHalt;
      end else if (req) begin
        en = legal;
        e.due   = cyc + 1;
        e.fault = !legal;
        e.insn  = legal ? ref_mem[addr[AW+1:2]] : 32'd0;
        sb.push_back(e);
        halt_pend = legal && (e.insn == HALT);
      end
    end
    @(negedge clk);
    chk("fetch_mem_en", {31'b0, mem_en}, {31'b0, en});
    if (en) begin
      chk("fetch_mem_we", {31'b0, mem_we}, 32'd0);
      chk("fetch_mem_addr", {22'b0, mem_addr}, {22'b0, addr[AW+1:2]});
    end
    step();
    fetch_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if (w == HALT) w = w ^ 32'h1;
    return w;
  endfunction

  task automatic random_fetches(input int n);
    int unsigned r;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) a = {20'b0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (r == 6) a = {20'b0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
      else if (r == 7) a = 32'($urandom_range(DEPTH, 32'h3fffffff)) << 2;
      else a = $urandom();
      drive(r <= 7, a);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
    #1;
    do_reset();

    // Small program ending in the halt word.
    load_word(NOP, 1'b0);
    load_word(NOP, 1'b0);
    load_word(NOP, 1'b0);
    load_word(HALT, 1'b1);
    check_after_load();
    drive(1'b1, 32'h0);
    drive(1'b1, 32'h4);
    drive(1'b1, 32'h8);
    drive(1'b1, 32'hC);
    drive(1'b1, 32'h0);
    drive(1'b1, 32'h4);
    drive(1'b0, 32'h0);
    @(negedge clk);
    chk("halted", {31'b0, halted}, 32'd1);
    chk("halt_core_run", {31'b0, core_run}, 32'd0);
    chk("halt_ld_ready", {31'b0, ld_ready}, 32'd0);
    step();

    // Fetches ignored in BOOT, then faults and random traffic in RUN.
    do_reset();
    drive(1'b1, 32'h0);
    drive(1'b1, 32'h6);
    n = $urandom_range(8, 20);
    for (int i = 0; i < n; i++) load_word(rand_word(), i == n - 1);
    check_after_load();
    drive(1'b1, 32'h6);
    drive(1'b1, 32'h1000);
    drive(1'b1, 32'h0);
    random_fetches(80);

    // Full-depth stream without ld_last.
    do_reset();
    for (int i = 0; i < DEPTH; i++) load_word(rand_word(), 1'b0);
    check_after_load();
    random_fetches(60);
    drive(1'b1, {20'b0, 10'(DEPTH - 1), 2'b00});

    // Reset with a fetch in flight.
    fetch_req  = 1'b1;
    fetch_addr = 32'h8;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("midrst_ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("midrst_load_count", {21'b0, load_count}, 32'd0);
    chk("midrst_core_run", {31'b0, core_run}, 32'd0);
    sb.delete();
    step();
    chk("midrst_valid_after_edge", {31'b0, fetch_valid}, 32'd0);
    fetch_req = 1'b0;
    mstate = MBoot;
    cnt = 0;
    halt_pend = 1'b0;
    rst = 1'b0;
    step();

    // Reload restarts at address 0; run to halt.
    load_word(rand_word(), 1'b0);
    load_word(HALT, 1'b1);
    check_after_load();
    drive(1'b1, 32'h0);
    drive(1'b1, 32'h4);
    drive(1'b1, 32'h8);
    drive(1'b1, 32'h0);
    drive(1'b0, 32'h0);
    @(negedge clk);
    chk("final_halted", {31'b0, halted}, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);
    if (halted) $display("program reached halt word");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
